// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, one stop bit, no parity.
// A small FIFO feeds the shifter so queued words leave back-to-back with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 7,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          serial_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [IDX_W-1:0]       bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [LVL_W-1:0]       level_n;
    logic                   serial_n, busy_n, ready_n;
    logic                   push, pop, fifo_empty, bit_done;

    assign fifo_empty = (fifo_level == '0);
    assign bit_done   = (cnt == CNT_LAST);
    assign push       = tx_valid && tx_ready;

    // NOTE: every output of this always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = bit_done ? '0 : cnt + CNT_W'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_n = shift >> 1;
                    if (bit_idx == IDX_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from next-state values and registered, so the line never glitches.
    always_comb begin
        serial_n = 1'b1;
        case (state_n)
            START:   serial_n = 1'b0;
            DATA:    serial_n = shift_n[0];
            default: serial_n = 1'b1;
        endcase

        level_n = fifo_level;
        case ({push, pop})
            2'b10:   level_n = fifo_level + LVL_W'(1);
            2'b01:   level_n = fifo_level - LVL_W'(1);
            default: level_n = fifo_level;
        endcase

        busy_n = (state_n != IDLE) || (level_n != '0);

        // A full FIFO still accepts on an edge that is guaranteed to pop, so the freed slot
        // is refilled in the same cycle; the full FIFO is non-empty, so that pop always happens.
        ready_n = (level_n != LVL_FULL) || (state_n == IDLE) ||
                  ((state_n == STOP) && (cnt_n == CNT_LAST));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            serial_tx  <= 1'b1;
            busy       <= 1'b0;
            tx_ready   <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            fifo_level <= level_n;
            serial_tx  <= serial_n;
            busy       <= busy_n;
            tx_ready   <= ready_n;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: FIFO storage has no reset; slots are only read after being written, and the
    // pointers/level reset is what flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, DATA_BITS=7, FIFO_DEPTH=4.
// Frames are checked cycle by cycle and decoded at mid-bit like a receiver would.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DB    = 7;
    localparam int DEPTH = 4;
    localparam int FRAME = CPB * (DB + 2);

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       serial_tx;
    logic       busy;
    logic [2:0] fifo_level;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .serial_tx (serial_tx),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks frame cycles first..last (cycle 0 = first start-bit cycle); leaves the bench
    // positioned at cycle last+1.
    task automatic check_frame(input logic [6:0] d, input int first, input int last);
        logic [6:0] rx;
        logic       exp_bit;
        int         b;
        rx = '0;
        for (int i = first; i <= last; i++) begin
            b = i / CPB;
            if (b == 0)       exp_bit = 1'b0;
            else if (b <= DB) exp_bit = d[b-1];
            else              exp_bit = 1'b1;
            check($sformatf("line %02h cyc %0d", d, i), serial_tx, exp_bit);
            check($sformatf("busy %02h cyc %0d", d, i), busy, 1);
            if ((i % CPB) == CPB / 2 && b >= 1 && b <= DB) rx[b-1] = serial_tx;
            tick();
        end
        if (first == 0 && last == FRAME - 1)
            check($sformatf("rx word %02h", d), rx, d);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " serial"}, serial_tx, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " level"}, fifo_level, 0);
        check({tag, " ready"}, tx_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;

        // Reset held three cycles, then released
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check_idle("reset");

        // Single word 0x55: line 0,1,0,1,0,1,0,1,1, each level 4 cycles
        tx_valid = 1'b1;
        tx_data  = 7'h55;
        tick();
        tx_valid = 1'b0;
        check("push55 level", fifo_level, 1);
        check("push55 busy", busy, 1);
        check("push55 line still idle", serial_tx, 1);
        check("push55 ready", tx_ready, 1);
        tick();
        check_frame(7'h55, 0, FRAME - 1);
        check_idle("after 55");

        // Three words on consecutive cycles -> contiguous frames
        tx_valid = 1'b1;
        tx_data  = 7'h01;
        tick();
        tx_data  = 7'h7F;
        tick();
        tx_data  = 7'h2A;
        check_frame(7'h01, 0, 0);
        tx_valid = 1'b0;
        check("burst level", fifo_level, 2);
        check_frame(7'h01, 1, FRAME - 1);
        check_frame(7'h7F, 0, FRAME - 1);
        check_frame(7'h2A, 0, FRAME - 1);
        check_idle("after burst");

        // Hold tx_valid: one word in flight plus four queued, the rest dropped
        tx_valid = 1'b1;
        tx_data  = 7'h11;
        tick();
        check("fill level0", fifo_level, 1);
        tx_data = 7'h21;
        tick();
        check("fill level1", fifo_level, 1);
        tx_data = 7'h32;
        tick();
        check("fill level2", fifo_level, 2);
        tx_data = 7'h43;
        tick();
        check("fill level3", fifo_level, 3);
        check("fill ready3", tx_ready, 1);
        tx_data = 7'h54;
        tick();
        check("full level", fifo_level, 4);
        check("full ready", tx_ready, 0);
        tx_data = 7'h65;
        tick();
        check("drop65 level", fifo_level, 4);
        check("drop65 ready", tx_ready, 0);
        tx_data = 7'h76;
        tick();
        check("drop76 level", fifo_level, 4);
        check("drop76 ready", tx_ready, 0);
        tx_valid = 1'b0;
        check_frame(7'h11, 5, FRAME - 2);

        // Push while full on the popping edge: accepted, level stays 4
        check("pop-edge ready", tx_ready, 1);
        check("pop-edge level", fifo_level, 4);
        tx_valid = 1'b1;
        tx_data  = 7'h0F;
        check_frame(7'h11, FRAME - 1, FRAME - 1);
        tx_valid = 1'b0;
        check("push+pop level", fifo_level, 4);
        check("push+pop ready", tx_ready, 0);
        check_frame(7'h21, 0, FRAME - 1);
        check_frame(7'h32, 0, FRAME - 1);
        check_frame(7'h43, 0, FRAME - 1);
        check_frame(7'h54, 0, FRAME - 1);
        check_frame(7'h0F, 0, FRAME - 1);
        check_idle("after fill");

        // Reset during data bit 3 aborts the frame and flushes the queue
        tx_valid = 1'b1;
        tx_data  = 7'h70;
        tick();
        tx_data  = 7'h3C;
        tick();
        tx_data  = 7'h5A;
        check_frame(7'h70, 0, 0);
        tx_valid = 1'b0;
        check_frame(7'h70, 1, 16);
        rst = 1'b1;
        check_frame(7'h70, 17, 17);
        rst = 1'b0;
        check_idle("mid-frame reset");
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post-reset line %0d", i), serial_tx, 1);
            check($sformatf("post-reset busy %0d", i), busy, 0);
        end

        // Clean frame after reset
        tx_valid = 1'b1;
        tx_data  = 7'h2B;
        tick();
        tx_valid = 1'b0;
        check("push2B level", fifo_level, 1);
        tick();
        check_frame(7'h2B, 0, FRAME - 1);
        check_idle("after 2B");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
